cache_fill_ctrl: RTL and testbench
==================================

CACHE_FILL_CTRL -- requirements
Module: cache_fill_ctrl

Interface
REQ-001 Parameter: WORDS, 8, 16-bit words per cache block (power of 2).
REQ-002 Parameter: ADDR_W, 16, byte-address width.
REQ-003 Port: clk  in  1  single clock, all state on posedge.
REQ-004 Port: rst  in  1  reset, asynchronous, active-high.
REQ-005 Port: i_miss  in  1  I-cache miss request, held until i_done.
REQ-006 Port: i_addr  in  ADDR_W  I-cache miss byte address.
REQ-007 Port: d_miss  in  1  D-cache miss request, held until d_done.
REQ-008 Port: d_addr  in  ADDR_W  D-cache miss byte address.
REQ-009 Port: mem_en  out  1  memory read issue strobe.
REQ-010 Port: mem_addr  out  ADDR_W  memory read byte address.
REQ-011 Port: mem_valid  in  1  read data returning this cycle, in issue order.
REQ-012 Port: mem_rdata  in  16  returned read data.
REQ-013 Port: fill_sel  out  1  cache being filled (0=I, 1=D).
REQ-014 Port: data_wr  out  1  data-array word write enable.
REQ-015 Port: data_wr_word  out  log2(WORDS)  word offset written.
REQ-016 Port: data_wr_data  out  16  word written (= mem_rdata).
REQ-017 Port: tag_wr  out  1  tag/valid write for the filled block.
REQ-018 Port: i_done, d_done  out  1 each  one-cycle fill-complete pulse.
REQ-019 Port: busy  out  1  high in any state other than IDLE.

Function
REQ-020 FSM states SHALL be IDLE, FILL, DRAIN, DONE.
REQ-021 IDLE: on any miss, grant one requester, latch base = addr with low log2(WORDS)+1 bits cleared, latch fill_sel, go FILL next cycle.
REQ-022 Both misses in the same IDLE cycle SHALL grant D (fixed priority) unless REQ-034 applies.
REQ-023 FILL: mem_en=1 each cycle, mem_addr = base + 2*issue_cnt, issue_cnt 0..WORDS-1; after issuing word WORDS-1 go DRAIN.
REQ-024 Each mem_valid in FILL or DRAIN SHALL produce data_wr=1, data_wr_word=ret_cnt, data_wr_data=mem_rdata that same cycle (combinational), then ret_cnt increments.
REQ-025 Return of word WORDS-1 SHALL move to DONE (from FILL or DRAIN); mem_valid in IDLE/DONE SHALL be ignored.
REQ-026 DONE: tag_wr=1 and exactly one of i_done/d_done (per fill_sel) high for one cycle; next state IDLE.
REQ-027 Miss deasserted mid-fill SHALL NOT abort; fill completes and done still pulses.
REQ-028 A requester still asserting miss in the IDLE cycle after DONE SHALL be treated as a new miss.
REQ-029 Counters SHALL be log2(WORDS) bits plus terminal detect; no wrap beyond WORDS-1 within one fill.
REQ-030 mem_en, data_wr, tag_wr SHALL be 0 outside FILL / FILL-or-DRAIN / DONE respectively.

Reset
REQ-031 rst SHALL asynchronously force IDLE, clear issue_cnt, ret_cnt, base, fill_sel.
REQ-032 During and after reset all outputs SHALL be 0 (mem_addr, data_wr_word, data_wr_data driven 0 when unused).
REQ-033 Reset mid-fill SHALL abandon the fill with no tag_wr or done pulse; late mem_valid after release is ignored.

Configuration
REQ-034 With FILL_ARB_RR_EN defined, simultaneous misses SHALL alternate grant via a last-granted bit (reset to I, so D wins first); without it, fixed D priority per REQ-022.

Structure
REQ-035 Shared package cache_pkg SHALL hold the FSM state enum, WORDS/ADDR_W defaults and the fill_sel encoding.
REQ-036 Arbitration SHALL be a sub-module fill_arb (requests in, one-hot grant out, last-granted state under FILL_ARB_RR_EN); counters/FSM stay in cache_fill_ctrl.

Verification
REQ-037 d_miss, d_addr=0x1234, memory 4-cycle latency -> mem_addr 0x1230..0x123E cycles 1-8, data_wr words 0-7 cycles 5-12, tag_wr+d_done cycle 13, busy low cycle 14.
REQ-038 i_miss and d_miss same cycle, fixed priority -> D filled first, I fill starts in IDLE cycle after d_done; with FILL_ARB_RR_EN second tie grants I.
REQ-039 Memory returns with 1-cycle gaps, last return after FILL -> DRAIN entered, all 8 words written in order, single done pulse.
REQ-040 i_miss dropped in cycle 3 of fill -> fill completes, i_done pulses once, no refill.
REQ-041 rst asserted cycle 6 of fill, stray mem_valid after release -> outputs 0, no data_wr/tag_wr, busy 0.
REQ-042 mem_valid asserted while IDLE, no miss -> no data_wr, no state change.

Source files
------------

// File: rtl/cache_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg
// Shared definitions for the cache fill controller: default geometry, the FSM
// state encoding, the fill_sel encoding and the arbiter grant bit positions.
// -----------------------------------------------------------------------------
package cache_pkg;

    // Default block geometry: 16-bit words per block and byte-address width
    localparam int WORDS_DEF  = 8;
    localparam int ADDR_W_DEF = 16;

    // fill_sel encoding: which cache owns the current fill
    localparam logic SEL_I = 1'b0;
    localparam logic SEL_D = 1'b1;

    // Bit positions inside the one-hot grant vector from fill_arb
    localparam int GNT_I = 0;
    localparam int GNT_D = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fill_state_e;

endpackage

// File: rtl/fill_arb.sv
// -----------------------------------------------------------------------------
// fill_arb
// Chooses which cache miss (I or D) is serviced next.
//
// Configuration macro: FILL_ARB_RR_EN
//   undefined : fixed priority, D wins a tie.
//   defined   : ties alternate using a last-granted bit (resets to I, so the
//               first tie goes to D).
//
// Ports
//   clk, rst   clock / async active-high reset (only with FILL_ARB_RR_EN)
//   take       the controller accepted the current grant (only with FILL_ARB_RR_EN)
//   req_i      I-cache miss request
//   req_d      D-cache miss request
//   gnt        one-hot grant, bit GNT_I / GNT_D
// -----------------------------------------------------------------------------
module fill_arb
    import cache_pkg::*;
(
`ifdef FILL_ARB_RR_EN
    input  logic       clk,
    input  logic       rst,
    input  logic       take,
`endif
    input  logic       req_i,
    input  logic       req_d,
    output logic [1:0] gnt
);

`ifdef FILL_ARB_RR_EN
    // last_d_q = 1 means D was granted most recently
    logic last_d_q;
    logic last_d_d;

    always_comb begin
        gnt = 2'b00;
        if (req_i && req_d) begin
            if (last_d_q) begin
                gnt[GNT_I] = 1'b1;
            end else begin
                gnt[GNT_D] = 1'b1;
            end
        end else if (req_d) begin
            gnt[GNT_D] = 1'b1;
        end else if (req_i) begin
            gnt[GNT_I] = 1'b1;
        end

        // The history only moves when the controller actually consumes a grant
        last_d_d = last_d_q;
        if (take) begin
            last_d_d = gnt[GNT_D];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_d_q <= 1'b0;
        end else begin
            last_d_q <= last_d_d;
        end
    end
`else
    always_comb begin
        gnt = 2'b00;
        if (req_d) begin
            gnt[GNT_D] = 1'b1;
        end else if (req_i) begin
            gnt[GNT_I] = 1'b1;
        end
    end
`endif

endmodule

// File: rtl/cache_fill_ctrl.sv
// -----------------------------------------------------------------------------
// cache_fill_ctrl
// Services I-cache and D-cache misses by reading a whole block from memory,
// writing each returned word into the data array and finally writing the tag.
//
// Configuration macro: FILL_ARB_RR_EN (round-robin tie break in fill_arb;
// default build uses fixed D priority).
//
// Ports
//   clk, rst        clock / async active-high reset
//   i_miss, i_addr  I-cache miss request (held until i_done) and byte address
//   d_miss, d_addr  D-cache miss request (held until d_done) and byte address
//   mem_en/mem_addr memory read issue strobe and byte address
//   mem_valid       read data returning this cycle (in issue order)
//   mem_rdata       returned read data
//   fill_sel        cache being filled (SEL_I / SEL_D)
//   data_wr, data_wr_word, data_wr_data   data-array word write
//   tag_wr          tag/valid write for the filled block
//   i_done, d_done  one-cycle fill-complete pulses
//   busy            controller not in IDLE
// -----------------------------------------------------------------------------
module cache_fill_ctrl
    import cache_pkg::*;
#(
    parameter int WORDS  = WORDS_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_miss,
    input  logic [ADDR_W-1:0]        i_addr,
    input  logic                     d_miss,
    input  logic [ADDR_W-1:0]        d_addr,
    output logic                     mem_en,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic                     mem_valid,
    input  logic [15:0]              mem_rdata,
    output logic                     fill_sel,
    output logic                     data_wr,
    output logic [$clog2(WORDS)-1:0] data_wr_word,
    output logic [15:0]              data_wr_data,
    output logic                     tag_wr,
    output logic                     i_done,
    output logic                     d_done,
    output logic                     busy
);

    localparam int OFF_W = $clog2(WORDS);

    // A block spans 2*WORDS bytes, so the block base clears the low OFF_W+1 bits
    localparam logic [ADDR_W-1:0] LOW_MASK  = ADDR_W'((2 * WORDS) - 1);
    localparam logic [OFF_W-1:0]  LAST_WORD = OFF_W'(WORDS - 1);

    fill_state_e        state_q, state_d;
    logic [OFF_W-1:0]   issue_cnt_q, issue_cnt_d;
    logic [OFF_W-1:0]   ret_cnt_q, ret_cnt_d;
    logic [ADDR_W-1:0]  base_q, base_d;
    logic               fill_sel_q, fill_sel_d;
    logic               mem_en_q, mem_en_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic               tag_wr_q, tag_wr_d;
    logic               i_done_q, i_done_d;
    logic               d_done_q, d_done_d;
    logic               busy_q, busy_d;

    logic [1:0]         gnt;
    logic               ret_fire;
    logic               issue_last;
    logic               ret_last;

`ifdef FILL_ARB_RR_EN
    logic arb_take;
    assign arb_take = (state_q == ST_IDLE) && (gnt != 2'b00);

    fill_arb u_arb (
        .clk   (clk),
        .rst   (rst),
        .take  (arb_take),
        .req_i (i_miss),
        .req_d (d_miss),
        .gnt   (gnt)
    );
`else
    fill_arb u_arb (
        .req_i (i_miss),
        .req_d (d_miss),
        .gnt   (gnt)
    );
`endif

    // Returns only count while a fill is in flight; anything else is stray
    assign ret_fire   = mem_valid && ((state_q == ST_FILL) || (state_q == ST_DRAIN));
    assign issue_last = (issue_cnt_q == LAST_WORD);
    assign ret_last   = (ret_cnt_q == LAST_WORD);

    // Data-array writes follow mem_valid in the same cycle
    assign data_wr      = ret_fire;
    assign data_wr_word = ret_fire ? ret_cnt_q : '0;
    assign data_wr_data = ret_fire ? mem_rdata : 16'h0000;

    assign mem_en   = mem_en_q;
    assign mem_addr = mem_addr_q;
    assign fill_sel = fill_sel_q;
    assign tag_wr   = tag_wr_q;
    assign i_done   = i_done_q;
    assign d_done   = d_done_q;
    assign busy     = busy_q;

    always_comb begin
        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        ret_cnt_d   = ret_cnt_q;
        base_d      = base_q;
        fill_sel_d  = fill_sel_q;

        unique case (state_q)
            ST_IDLE: begin
                if (gnt != 2'b00) begin
                    fill_sel_d  = gnt[GNT_D] ? SEL_D : SEL_I;
                    base_d      = (gnt[GNT_D] ? d_addr : i_addr) & ~LOW_MASK;
                    issue_cnt_d = '0;
                    ret_cnt_d   = '0;
                    state_d     = ST_FILL;
                end
            end
            ST_FILL: begin
                // Counter holds at the last word rather than wrapping
                if (issue_last) begin
                    state_d = ST_DRAIN;
                end else begin
                    issue_cnt_d = issue_cnt_q + 1'b1;
                end
            end
            ST_DRAIN: begin
            end
            ST_DONE: begin
                // Dropping fill_sel here keeps it low whenever we sit in IDLE
                fill_sel_d = SEL_I;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The final return wins over the FILL->DRAIN step when both coincide
        if (ret_fire) begin
            if (ret_last) begin
                state_d = ST_DONE;
            end else begin
                ret_cnt_d = ret_cnt_q + 1'b1;
            end
        end

        // Outputs are registered from the next-state view so they line up
        // exactly with the state they describe
        mem_en_d   = (state_d == ST_FILL);
        mem_addr_d = mem_en_d ? (base_d + (ADDR_W'(issue_cnt_d) << 1)) : '0;
        tag_wr_d   = (state_d == ST_DONE);
        i_done_d   = (state_d == ST_DONE) && (fill_sel_d == SEL_I);
        d_done_d   = (state_d == ST_DONE) && (fill_sel_d == SEL_D);
        busy_d     = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
            base_q      <= '0;
            fill_sel_q  <= SEL_I;
            mem_en_q    <= 1'b0;
            mem_addr_q  <= '0;
            tag_wr_q    <= 1'b0;
            i_done_q    <= 1'b0;
            d_done_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            ret_cnt_q   <= ret_cnt_d;
            base_q      <= base_d;
            fill_sel_q  <= fill_sel_d;
            mem_en_q    <= mem_en_d;
            mem_addr_q  <= mem_addr_d;
            tag_wr_q    <= tag_wr_d;
            i_done_q    <= i_done_d;
            d_done_q    <= d_done_d;
            busy_q      <= busy_d;
        end
    end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cache_fill_ctrl
// Directed bench for cache_fill_ctrl with a small in-order memory model whose
// latency and return gaps are controlled from the main sequence.
// -----------------------------------------------------------------------------
module tb_cache_fill_ctrl;

    logic        clk;
    logic        rst;
    logic        i_miss;
    logic [15:0] i_addr;
    logic        d_miss;
    logic [15:0] d_addr;
    logic        mem_en;
    logic [15:0] mem_addr;
    logic        mem_valid;
    logic [15:0] mem_rdata;
    logic        fill_sel;
    logic        data_wr;
    logic [2:0]  data_wr_word;
    logic [15:0] data_wr_data;
    logic        tag_wr;
    logic        i_done;
    logic        d_done;
    logic        busy;

    int n_checks = 0;
    int n_err    = 0;

    // Memory model controls
    int          lat         = 4;
    bit          gap_mode    = 1'b0;
    bit          force_valid = 1'b0;
    logic [15:0] pend_addr[$];
    int          pend_rdy[$];
    int          mcyc        = 0;
    bit          gave_last   = 1'b0;

    cache_fill_ctrl #(
        .WORDS  (8),
        .ADDR_W (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_miss       (i_miss),
        .i_addr       (i_addr),
        .d_miss       (d_miss),
        .d_addr       (d_addr),
        .mem_en       (mem_en),
        .mem_addr     (mem_addr),
        .mem_valid    (mem_valid),
        .mem_rdata    (mem_rdata),
        .fill_sel     (fill_sel),
        .data_wr      (data_wr),
        .data_wr_word (data_wr_word),
        .data_wr_data (data_wr_data),
        .tag_wr       (tag_wr),
        .i_done       (i_done),
        .d_done       (d_done),
        .busy         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a ^ 16'h5A5A;
    endfunction

    // Memory: every issued read comes back lat cycles later, in order
    initial begin
        mem_valid = 1'b0;
        mem_rdata = 16'h0000;
        forever begin
            @(posedge clk);
            #1;
            mcyc++;
            if (mem_en === 1'b1) begin
                pend_addr.push_back(mem_addr);
                pend_rdy.push_back(mcyc + lat);
            end
            mem_valid = 1'b0;
            mem_rdata = 16'h0000;
            if (force_valid) begin
                mem_valid = 1'b1;
                mem_rdata = 16'hDEAD;
            end else if (pend_rdy.size() > 0 && pend_rdy[0] <= mcyc && !(gap_mode && gave_last)) begin
                mem_valid = 1'b1;
                mem_rdata = mem_word(pend_addr[0]);
                void'(pend_addr.pop_front());
                void'(pend_rdy.pop_front());
            end
            gave_last = mem_valid;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ctl"}, {25'd0, mem_en, fill_sel, data_wr, tag_wr, i_done, d_done, busy}, 32'd0);
        check({tag, "_addr"}, {16'd0, mem_addr}, 32'd0);
        check({tag, "_wdata"}, {13'd0, data_wr_word, data_wr_data}, 32'd0);
    endtask

    task automatic wait_done(input bit want_d, input int budget, input string tag);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if ((want_d ? d_done : i_done) === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check(tag, {31'd0, seen}, 32'd1);
    endtask

    initial begin
        logic [15:0] exp_addr;
        logic [15:0] exp_data;
        logic [2:0]  exp_word;
        logic        exp_en;
        logic        exp_wr;
        logic        exp_sel;
        logic [15:0] exp_addr2;
        int          nexp;
        int          ndone;
        int          ndd;
        int          en_cnt;
        int          wr_cnt;
        int          act_cnt;
        bit          drop;

        rst    = 1'b1;
        i_miss = 1'b0;
        d_miss = 1'b0;
        i_addr = 16'h0000;
        d_addr = 16'h0000;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_zero("post_reset");

        // D miss at 0x1234, 4-cycle memory, cycle-by-cycle timeline
        lat = 4;
        tick();
        d_addr = 16'h1234;
        d_miss = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            tick();
            if (c == 14) d_miss = 1'b0;
            @(negedge clk);
            exp_en   = (c >= 1 && c <= 8);
            exp_addr = exp_en ? 16'h1230 + 16'(2 * (c - 1)) : 16'h0000;
            exp_wr   = (c >= 5 && c <= 12);
            exp_word = exp_wr ? 3'(c - 5) : 3'd0;
            exp_data = exp_wr ? mem_word(16'h1230 + 16'(2 * (c - 5))) : 16'h0000;
            check($sformatf("t1_c%0d_mem_en", c), {31'd0, mem_en}, {31'd0, exp_en});
            check($sformatf("t1_c%0d_mem_addr", c), {16'd0, mem_addr}, {16'd0, exp_addr});
            check($sformatf("t1_c%0d_data_wr", c), {31'd0, data_wr}, {31'd0, exp_wr});
            check($sformatf("t1_c%0d_wr_word_data", c), {13'd0, data_wr_word, data_wr_data},
                  {13'd0, exp_word, exp_data});
            check($sformatf("t1_c%0d_tag_done", c), {29'd0, tag_wr, d_done, i_done},
                  {29'd0, (c == 13), (c == 13), 1'b0});
            check($sformatf("t1_c%0d_busy_sel", c), {30'd0, busy, fill_sel},
                  {30'd0, (c <= 13), (c <= 13)});
        end
        idle(3);

        // Simultaneous misses: D first, then I once D lets go
        lat = 1;
        tick();
        i_addr = 16'h0456;
        d_addr = 16'h2FFF;
        i_miss = 1'b1;
        d_miss = 1'b1;
        tick();
        @(negedge clk);
        check("t2_first_grant", {15'd0, mem_en, fill_sel, mem_addr}, {15'd0, 1'b1, 1'b1, 16'h2FF0});
        wait_done(1'b1, 40, "t2_d_done_seen");
        check("t2_no_i_done", {31'd0, i_done}, 32'd0);
        tick();
        d_miss = 1'b0;
        @(negedge clk);
        check("t2_idle_between", {31'd0, busy}, 32'd0);
        tick();
        @(negedge clk);
        check("t2_i_grant", {15'd0, mem_en, fill_sel, mem_addr}, {15'd0, 1'b1, 1'b0, 16'h0450});
        wait_done(1'b0, 40, "t2_i_done_seen");
        tick();
        i_miss = 1'b0;
        idle(3);

        // Second tie with D still held after its fill
`ifdef FILL_ARB_RR_EN
        exp_sel   = 1'b0;
        exp_addr2 = 16'h0450;
`else
        exp_sel   = 1'b1;
        exp_addr2 = 16'h2FF0;
`endif
        tick();
        i_miss = 1'b1;
        d_miss = 1'b1;
        tick();
        @(negedge clk);
        check("t2b_first_sel", {31'd0, fill_sel}, 32'd1);
        wait_done(1'b1, 40, "t2b_d_done_seen");
        tick();
        @(negedge clk);
        check("t2b_idle_between", {31'd0, busy}, 32'd0);
        tick();
        i_miss = 1'b0;
        d_miss = 1'b0;
        @(negedge clk);
        check("t2b_second_grant", {15'd0, mem_en, fill_sel, mem_addr}, {15'd0, 1'b1, exp_sel, exp_addr2});
        wait_done(exp_sel, 40, "t2b_second_done_seen");
        idle(3);

        // Returns with gaps that extend past the issue phase
        lat      = 2;
        gap_mode = 1'b1;
        tick();
        i_addr = 16'h8ABC;
        i_miss = 1'b1;
        nexp   = 0;
        ndone  = 0;
        ndd    = 0;
        drop   = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (drop) begin
                i_miss = 1'b0;
                drop   = 1'b0;
            end
            @(negedge clk);
            if (data_wr === 1'b1) begin
                check($sformatf("t3_word%0d_idx", nexp), {29'd0, data_wr_word}, {29'd0, 3'(nexp)});
                check($sformatf("t3_word%0d_data", nexp), {16'd0, data_wr_data},
                      {16'd0, mem_word(16'h8AB0 + 16'(2 * nexp))});
                nexp++;
            end
            if (i_done === 1'b1) begin
                ndone++;
                drop = 1'b1;
            end
            if (d_done === 1'b1) ndd++;
            if (c == 10) check("t3_drain", {30'd0, busy, mem_en}, {30'd0, 1'b1, 1'b0});
        end
        i_miss   = 1'b0;
        gap_mode = 1'b0;
        check("t3_words_written", nexp, 8);
        check("t3_i_done_pulses", ndone, 1);
        check("t3_no_d_done", ndd, 0);
        idle(3);

        // Miss dropped mid-fill: no abort, no refill
        lat = 1;
        tick();
        i_addr = 16'h0100;
        i_miss = 1'b1;
        en_cnt = 0;
        wr_cnt = 0;
        ndone  = 0;
        for (int c = 1; c <= 25; c++) begin
            tick();
            if (c == 3) i_miss = 1'b0;
            @(negedge clk);
            if (mem_en === 1'b1)  en_cnt++;
            if (data_wr === 1'b1) wr_cnt++;
            if (i_done === 1'b1)  ndone++;
        end
        check("t4_issues", en_cnt, 8);
        check("t4_writes", wr_cnt, 8);
        check("t4_i_done_pulses", ndone, 1);
        idle(2);

        // Reset mid-fill, then stray returns after release
        lat = 4;
        tick();
        d_addr = 16'h4000;
        d_miss = 1'b1;
        idle(5);
        tick();
        rst    = 1'b1;
        d_miss = 1'b0;
        @(negedge clk);
        check_zero("t5_in_reset");
        tick();
        @(negedge clk);
        check_zero("t5_reset_hold");
        tick();
        rst     = 1'b0;
        act_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if ((data_wr | tag_wr | d_done | i_done | busy | mem_en) === 1'b1) act_cnt++;
        end
        check("t5_no_activity", act_cnt, 0);
        check_zero("t5_after");
        idle(10);

        // mem_valid while idle with no miss
        tick();
        force_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            @(negedge clk);
            check($sformatf("t6_k%0d_idle", k), {14'd0, data_wr, busy, data_wr_data}, 32'd0);
        end
        force_valid = 1'b0;
        idle(2);
        check_zero("t6_after");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
